aes_block_packer: RTL and testbench
===================================

Name: aes_block_packer

Overview:
Input-side stage of the AES HWPE datapath. It accepts the 32-bit HWPE input stream and packs each run of 4 words into a 128-bit plaintext/ciphertext block. It presents each block to the engine/core with a valid/ready handshake. An assembly register and an output register together let the next block be streamed in while the current block waits for the core.

Parameters:
- WORD_ORDER, 0: word placement. 0 = first word to [127:96], last word to [31:0]. 1 = first word to [31:0], last word to [127:96].
- CNT_W, 16: width of the delivered-block counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- clear_i  in  1  synchronous soft clear from controller
- in_data_i  in  32  input stream data
- in_strb_i  in  4  input byte strobes
- in_valid_i  in  1  input stream valid
- in_ready_o  out  1  input stream ready
- blk_data_o  out  128  assembled block to core
- blk_valid_o  out  1  block valid
- blk_ready_i  in  1  core/engine accepts block
- word_cnt_o  out  2  words held in assembly register (0..3)
- blocks_o  out  CNT_W  blocks delivered since reset/clear
- strb_err_o  out  1  sticky: a word was accepted with strb != 4'hF
- busy_o  out  1  any partial or complete block held

Behaviour:
- Interface: clock clk_i; reset rst_ni, asynchronous, active-low. All state is registered on the rising edge of clk_i.
- Reset values: word_cnt=0, asm_full=0, asm_data=0, blk_valid_o=0, blk_data_o=0, blocks_o=0, strb_err_o=0. in_ready_o=1 after reset, because it is derived from asm_full.
- Input handshake: a word is accepted when in_valid_i & in_ready_o. in_ready_o = !asm_full. It is combinational from state only and never depends on in_valid_i.
- On each accepted word:
  - The word is written into slot word_cnt. Slot 0 is the first word; placement follows WORD_ORDER.
  - Any byte whose strobe bit is 0 is stored as 8'h00, and strb_err_o is set (sticky).
  - word_cnt increments and wraps 3->0.
- Block completion: the cycle in which the 4th word is accepted.
  - If the output register is free (!blk_valid_o | blk_ready_i), the complete block, including the word accepted that cycle, loads directly into blk_data_o. blk_valid_o is 1 on the next cycle (latency 1 from the last-word handshake).
  - Otherwise asm_full is set, and in_ready_o goes 0 from the next cycle.
- Stall drain: while asm_full=1 and the output register is free, asm_data moves to blk_data_o, blk_valid_o=1 and asm_full clears. in_ready_o returns to 1 on the following cycle.
- Output handshake: a block is transferred when blk_valid_o & blk_ready_i.
  - blocks_o increments by 1 and wraps modulo 2^CNT_W.
  - blk_valid_o clears unless a new block loads in the same cycle, in which case it stays 1.
- Output stability: blk_data_o and blk_valid_o stay stable while blk_valid_o=1 and blk_ready_i=0. No data is ever dropped or overwritten.
- Simultaneous events: a last-word accept and an output handshake in the same cycle give back-to-back blocks with no bubble. Sustained throughput is 1 word/cycle as long as the core accepts at least 1 block per 4 cycles.
- Clear: clear_i has priority over every handshake in the same cycle.
  - It zeroes word_cnt, asm_full, blk_valid_o, blocks_o and strb_err_o, and discards any partial or held block.
  - Data registers may keep stale contents.
  - No transfer completes in a clear cycle: blocks_o does not increment and no word is stored.
  - in_ready_o is unaffected in the clear cycle itself.
- Reset mid-block: the partial block is lost; state returns to reset values immediately.
- busy_o = (word_cnt!=0) | asm_full | blk_valid_o.

Test Plan:
- Basic pack, WORD_ORDER=0, blk_ready_i=1: input words 32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF -> one cycle after the 4th accept, blk_valid_o=1 with blk_data_o=128'h00112233_44556677_8899AABB_CCDDEEFF; blocks_o=1. Repeat with WORD_ORDER=1 -> 128'hCCDDEEFF_8899AABB_44556677_00112233.
- Backpressure: blk_ready_i=0, stream 8 words continuously -> block 1 held stable and block 2 assembled; asm_full=1 and in_ready_o=0 after word 8; the 9th word is not accepted. Raise blk_ready_i -> block 1 and then block 2 delivered on consecutive handshakes; blocks_o=2; in_ready_o returns to 1.
- Streaming throughput: 16 consecutive words, blk_ready_i=1 -> 4 blocks, in_ready_o held 1 throughout, blk_valid_o pulses every 4 cycles, blocks_o=4.
- Strobe: 2nd word 32'hAABBCCDD with strb 4'b0101 -> stored as 32'h00BB00DD; strb_err_o=1 and it stays 1 until clear_i.
- Clear mid-block: accept 2 words, assert clear_i for 1 cycle together with an in_valid_i word -> word_cnt=0, strb_err_o=0, busy_o=0; the next 4 words form a clean block with no stale data.
- Async reset while blk_valid_o=1 and blk_ready_i=0 -> blk_valid_o=0, blocks_o=0, in_ready_o=1 immediately; counter wrap checked with CNT_W=2 (5 blocks -> blocks_o=1).

Source files
------------

// File: rtl/aes_block_packer.sv
// Packs the 32-bit HWPE input stream into 128-bit AES blocks.
// An assembly register and an output register let the next block stream in while the core is busy.
module aes_block_packer #(
    parameter int unsigned WORD_ORDER = 0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic [31:0]      in_data_i,
    input  logic [3:0]       in_strb_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [127:0]     blk_data_o,
    output logic             blk_valid_o,
    input  logic             blk_ready_i,
    output logic [1:0]       word_cnt_o,
    output logic [CNT_W-1:0] blocks_o,
    output logic             strb_err_o,
    output logic             busy_o
);

    localparam int unsigned BYTES = 4;

    logic [1:0]       word_cnt_q, word_cnt_d;
    logic             asm_full_q, asm_full_d;
    logic [127:0]     asm_data_q, asm_data_d;
    logic [127:0]     blk_data_d;
    logic             blk_valid_d;
    logic [CNT_W-1:0] blocks_d;
    logic             strb_err_d;

    logic [31:0]      word_masked;
    logic [127:0]     asm_ins;
    logic [1:0]       slot_pos;
    logic [6:0]       slot_base;
    logic             accept, last_word, out_free, xfer;

    assign in_ready_o = !asm_full_q;
    assign word_cnt_o = word_cnt_q;
    assign busy_o     = (word_cnt_q != 2'd0) | asm_full_q | blk_valid_o;

    assign accept    = in_valid_i & in_ready_o;
    assign last_word = accept & (word_cnt_q == 2'd3);
    assign out_free  = !blk_valid_o | blk_ready_i;
    assign xfer      = blk_valid_o & blk_ready_i;

    // Zero every byte whose strobe is low.
    always_comb begin
        word_masked = '0;
        for (int b = 0; b < BYTES; b++) begin
            word_masked[8*b +: 8] = in_strb_i[b] ? in_data_i[8*b +: 8] : 8'h00;
        end
    end

    // Slot 0 lands in the top word for order 0, in the bottom word for order 1.
    assign slot_pos  = (WORD_ORDER == 0) ? ~word_cnt_q : word_cnt_q;
    assign slot_base = {slot_pos, 5'd0};

    always_comb begin
        asm_ins = asm_data_q;
        asm_ins[slot_base +: 32] = word_masked;
    end

    always_comb begin
        word_cnt_d  = word_cnt_q;
        asm_full_d  = asm_full_q;
        asm_data_d  = asm_data_q;
        blk_data_d  = blk_data_o;
        blk_valid_d = blk_valid_o;
        blocks_d    = blocks_o;
        strb_err_d  = strb_err_o;

        if (clear_i) begin
            word_cnt_d  = 2'd0;
            asm_full_d  = 1'b0;
            blk_valid_d = 1'b0;
            blocks_d    = '0;
            strb_err_d  = 1'b0;
        end else begin
            if (xfer) begin
                blocks_d    = blocks_o + CNT_W'(1);
                blk_valid_d = 1'b0;
            end
            if (accept) begin
                asm_data_d = asm_ins;
                word_cnt_d = word_cnt_q + 2'd1;
                if (in_strb_i != 4'hF) begin
                    strb_err_d = 1'b1;
                end
            end
            // A held block drains first; no word can be accepted while it is held.
            if (asm_full_q && out_free) begin
                blk_data_d  = asm_data_q;
                blk_valid_d = 1'b1;
                asm_full_d  = 1'b0;
            end else if (last_word && out_free) begin
                blk_data_d  = asm_ins;
                blk_valid_d = 1'b1;
            end else if (last_word) begin
                asm_full_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_cnt_q  <= 2'd0;
            asm_full_q  <= 1'b0;
            asm_data_q  <= '0;
            blk_data_o  <= '0;
            blk_valid_o <= 1'b0;
            blocks_o    <= '0;
            strb_err_o  <= 1'b0;
        end else begin
            word_cnt_q  <= word_cnt_d;
            asm_full_q  <= asm_full_d;
            asm_data_q  <= asm_data_d;
            blk_data_o  <= blk_data_d;
            blk_valid_o <= blk_valid_d;
            blocks_o    <= blocks_d;
            strb_err_o  <= strb_err_d;
        end
    end

endmodule

// File: tb/tb_aes_block_packer.sv
// Self-checking bench: two packer instances (word order 0 / 16-bit count, word order 1 / 2-bit count)
// driven by one stream and checked against a queue-based block model.
module tb_aes_block_packer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clear;
    logic [31:0]  in_data;
    logic [3:0]   in_strb;
    logic         in_valid;
    logic         blk_ready;

    logic         in_ready0, in_ready1;
    logic [127:0] blk_data0, blk_data1;
    logic         blk_valid0, blk_valid1;
    logic [1:0]   word_cnt0, word_cnt1;
    logic [15:0]  blocks0;
    logic [1:0]   blocks1;
    logic         strb_err0, strb_err1;
    logic         busy0, busy1;

    int checks = 0;
    int errors = 0;

    // Model: words of the partial block, and complete blocks waiting for the core (order-0 layout).
    logic [31:0]  m_part[$];
    logic [127:0] m_q[$];
    int           m_blocks;
    logic         m_err;

    always #5 clk = ~clk;

    aes_block_packer #(.WORD_ORDER(0), .CNT_W(16)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .in_data_i(in_data), .in_strb_i(in_strb), .in_valid_i(in_valid), .in_ready_o(in_ready0),
        .blk_data_o(blk_data0), .blk_valid_o(blk_valid0), .blk_ready_i(blk_ready),
        .word_cnt_o(word_cnt0), .blocks_o(blocks0), .strb_err_o(strb_err0), .busy_o(busy0)
    );

    aes_block_packer #(.WORD_ORDER(1), .CNT_W(2)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .in_data_i(in_data), .in_strb_i(in_strb), .in_valid_i(in_valid), .in_ready_o(in_ready1),
        .blk_data_o(blk_data1), .blk_valid_o(blk_valid1), .blk_ready_i(blk_ready),
        .word_cnt_o(word_cnt1), .blocks_o(blocks1), .strb_err_o(strb_err1), .busy_o(busy1)
    );

    typedef struct {
        logic        vld;
        logic [31:0] data;
        logic        rdy;
        logic [1:0]  e_cnt;
        logic        e_valid;
        logic [15:0] e_blocks;
    } vec_t;

    vec_t tbl[5];

    function automatic logic [127:0] swap_words(input logic [127:0] x);
        return {x[31:0], x[63:32], x[95:64], x[127:96]};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [31:0] d, input logic [3:0] s,
                          input logic r, input logic c);
        in_valid  = v;
        in_data   = d;
        in_strb   = s;
        blk_ready = r;
        clear     = c;
    endtask

    function automatic void model_reset();
        m_part.delete();
        m_q.delete();
        m_blocks = 0;
        m_err    = 1'b0;
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    function automatic void model_edge();
        bit acc, xf;
        logic [31:0] w;
        acc = in_valid && (m_q.size() < 2);
        xf  = (m_q.size() > 0) && blk_ready;
        if (clear) begin
            model_reset();
            return;
        end
        if (xf) begin
            void'(m_q.pop_front());
            m_blocks++;
        end
        if (acc) begin
            for (int b = 0; b < 4; b++) w[8*b +: 8] = in_strb[b] ? in_data[8*b +: 8] : 8'h00;
            if (in_strb != 4'hF) m_err = 1'b1;
            m_part.push_back(w);
            if (m_part.size() == 4) begin
                m_q.push_back({m_part[0], m_part[1], m_part[2], m_part[3]});
                m_part.delete();
            end
        end
    endfunction

    task automatic compare_all();
        logic exp_valid;
        exp_valid = (m_q.size() > 0);
        chk("in_ready0", 128'(in_ready0), 128'(m_q.size() < 2));
        chk("in_ready1", 128'(in_ready1), 128'(m_q.size() < 2));
        chk("blk_valid0", 128'(blk_valid0), 128'(exp_valid));
        chk("blk_valid1", 128'(blk_valid1), 128'(exp_valid));
        chk("word_cnt0", 128'(word_cnt0), 128'(m_part.size()));
        chk("word_cnt1", 128'(word_cnt1), 128'(m_part.size()));
        chk("blocks0", 128'(blocks0), 128'(m_blocks % 65536));
        chk("blocks1", 128'(blocks1), 128'(m_blocks % 4));
        chk("strb_err0", 128'(strb_err0), 128'(m_err));
        chk("strb_err1", 128'(strb_err1), 128'(m_err));
        chk("busy0", 128'(busy0), 128'((m_part.size() > 0) || exp_valid));
        chk("busy1", 128'(busy1), 128'((m_part.size() > 0) || exp_valid));
        if (exp_valid) begin
            chk("blk_data0", blk_data0, m_q[0]);
            chk("blk_data1", blk_data1, swap_words(m_q[0]));
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic word(input logic [31:0] d, input logic r);
        set_in(1'b1, d, 4'hF, r, 1'b0);
        step();
    endtask

    task automatic idle(input logic r);
        set_in(1'b0, 32'h0, 4'hF, r, 1'b0);
        step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int vcount, nready;
    int b_before;

    initial begin
        tbl[0] = '{1'b1, 32'h00112233, 1'b1, 2'd1, 1'b0, 16'd0};
        tbl[1] = '{1'b1, 32'h44556677, 1'b1, 2'd2, 1'b0, 16'd0};
        tbl[2] = '{1'b1, 32'h8899AABB, 1'b1, 2'd3, 1'b0, 16'd0};
        tbl[3] = '{1'b1, 32'hCCDDEEFF, 1'b1, 2'd0, 1'b1, 16'd0};
        tbl[4] = '{1'b0, 32'h00000000, 1'b1, 2'd0, 1'b0, 16'd1};

        set_in(1'b0, 32'h0, 4'hF, 1'b0, 1'b0);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 128'(in_ready0), 128'(1));
        chk("rst_blk_valid", 128'(blk_valid0), 128'(0));
        chk("rst_blk_data", blk_data0, 128'h0);
        chk("rst_blocks", 128'(blocks0), 128'(0));
        chk("rst_busy", 128'(busy1), 128'(0));
        rst_n = 1'b1;

        // Basic pack from the table
        for (int i = 0; i < 5; i++) begin
            set_in(tbl[i].vld, tbl[i].data, 4'hF, tbl[i].rdy, 1'b0);
            step();
            chk("tbl_cnt", 128'(word_cnt0), 128'(tbl[i].e_cnt));
            chk("tbl_valid", 128'(blk_valid0), 128'(tbl[i].e_valid));
            chk("tbl_blocks", 128'(blocks0), 128'(tbl[i].e_blocks));
            if (tbl[i].e_valid) begin
                chk("tbl_data_o0", blk_data0, 128'h00112233_44556677_8899AABB_CCDDEEFF);
                chk("tbl_data_o1", blk_data1, 128'hCCDDEEFF_8899AABB_44556677_00112233);
            end
        end

        // Backpressure: two blocks held, ninth word refused, then drained back to back
        for (int i = 0; i < 8; i++) word(32'hB0000000 + 32'(i), 1'b0);
        chk("bp_in_ready", 128'(in_ready0), 128'(0));
        word(32'hB0000008, 1'b0);
        chk("bp_no_accept", 128'(word_cnt0), 128'(0));
        chk("bp_held", blk_data0, 128'hB0000000_B0000001_B0000002_B0000003);
        idle(1'b1);
        chk("bp_blk2", blk_data0, 128'hB0000004_B0000005_B0000006_B0000007);
        chk("bp_ready_back", 128'(in_ready0), 128'(1));
        idle(1'b1);
        chk("bp_blocks", 128'(blocks0), 128'(3));

        // Streaming throughput
        vcount = 0;
        nready = 0;
        b_before = int'(blocks0);
        for (int i = 0; i < 16; i++) begin
            if (!in_ready0) nready++;
            word($urandom, 1'b1);
            if (blk_valid0) vcount++;
        end
        idle(1'b1);
        chk("st_ready_held", 128'(nready), 128'(0));
        chk("st_pulses", 128'(vcount), 128'(4));
        chk("st_blocks", 128'(int'(blocks0) - b_before), 128'(4));

        // Strobe masking and sticky error
        word(32'h11111111, 1'b1);
        set_in(1'b1, 32'hAABBCCDD, 4'b0101, 1'b1, 1'b0);
        step();
        word(32'h33333333, 1'b1);
        word(32'h44444444, 1'b1);
        chk("strb_word", 128'(blk_data0[95:64]), 128'(32'h00BB00DD));
        idle(1'b1);
        idle(1'b1);
        chk("strb_sticky", 128'(strb_err0), 128'(1));

        // Clear mid-block together with a valid word
        word(32'hDEAD0001, 1'b1);
        word(32'hDEAD0002, 1'b1);
        set_in(1'b1, 32'hDEAD0003, 4'hF, 1'b1, 1'b1);
        step();
        chk("clr_cnt", 128'(word_cnt0), 128'(0));
        chk("clr_err", 128'(strb_err0), 128'(0));
        chk("clr_busy", 128'(busy0), 128'(0));
        chk("clr_blocks", 128'(blocks0), 128'(0));
        word(32'hC0000001, 1'b1);
        word(32'hC0000002, 1'b1);
        word(32'hC0000003, 1'b1);
        word(32'hC0000004, 1'b1);
        chk("clr_clean", blk_data0, 128'hC0000001_C0000002_C0000003_C0000004);
        idle(1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom % 4) != 0, $urandom,
                   (($urandom % 8) == 0) ? 4'($urandom) : 4'hF,
                   ($urandom % 3) != 0, ($urandom % 97) == 0);
            step();
        end

        // Asynchronous reset while a block is held
        for (int i = 0; i < 4; i++) word(32'hA5A50000 + 32'(i), 1'b0);
        idle(1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 128'(blk_valid0), 128'(0));
        chk("arst_blocks", 128'(blocks0), 128'(0));
        chk("arst_ready", 128'(in_ready1), 128'(1));
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Counter wrap: five blocks
        for (int i = 0; i < 20; i++) word(32'(i), 1'b1);
        idle(1'b1);
        chk("wrap_blocks1", 128'(blocks1), 128'(1));
        chk("wrap_blocks0", 128'(blocks0), 128'(5));

        do_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
